// File: rtl/fp_op_sequencer_pkg.sv
// Shared types for the FP issue sequencer: FSM states, FP sub-unit selector, command union and
// the IEEE exception flag set.
package fp_op_sequencer_pkg;

  typedef enum logic [1:0] {
    FpSeqIdle,
    FpSeqBusy,
    FpSeqWb
  } fp_seq_state_e;

  typedef enum logic [2:0] {
    FpUnitAdd  = 3'd0,
    FpUnitMul  = 3'd1,
    FpUnitFma  = 3'd2,
    FpUnitDiv  = 3'd3,
    FpUnitSqrt = 3'd4,
    FpUnitCvt  = 3'd5,
    FpUnitCmp  = 3'd6,
    FpUnitMove = 3'd7
  } fp_unit_e;

  typedef enum logic [3:0] {
    FmaMadd  = 4'd0,
    FmaMsub  = 4'd1,
    FmaNmsub = 4'd2,
    FmaNmadd = 4'd3
  } fp_fma_cmd_e;

  typedef enum logic [3:0] {
    MoveIntToFp = 4'd0,
    MoveFpToInt = 4'd1,
    MoveSgnj    = 4'd2
  } fp_move_cmd_e;

  typedef union packed {
    logic [3:0]   raw;
    fp_fma_cmd_e  fma;
    fp_move_cmd_e move;
  } fp_command_u;

  // Bit order matches the fflags CSR: NV DZ OF UF NX (NX is bit 0).
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic fflags_t mask_flags(input logic write, input fflags_t value);
    return write ? value : fflags_t'('0);
  endfunction

endpackage

// File: rtl/fp_op_sequencer_busy_watchdog.sv
// Busy-cycle counter that pulses when an operation has stayed busy for WATCHDOG_CYCLES cycles.
module fp_op_sequencer_busy_watchdog
  import fp_op_sequencer_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WATCHDOG_CYCLES - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CntW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LastCount);

endmodule

// File: rtl/fp_op_sequencer.sv
// Issue-side FP controller: latches one request, holds the unit enabled until done, then
// presents a single-cycle writeback and folds the reported flags into a sticky accumulator.
module fp_op_sequencer
  import fp_op_sequencer_pkg::*;
#(
  parameter int unsigned FP_WIDTH        = 32,
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  fp_unit_e            i_req_unit,
  input  fp_command_u         i_req_command,
  input  logic [2:0]          i_req_rounding_mode,
  input  logic [4:0]          i_req_rd,
  input  logic                i_req_rd_is_int,
  input  logic [31:0]         i_req_int_src1,
  input  logic [31:0]         i_req_int_src2,
  input  logic [FP_WIDTH-1:0] i_req_fp_src1,
  input  logic [FP_WIDTH-1:0] i_req_fp_src2,
  input  logic [FP_WIDTH-1:0] i_req_fp_src3,
  output logic                o_fpu_enable,
  output logic                o_fpu_flush,
  output fp_unit_e            o_fpu_unit,
  output fp_command_u         o_fpu_command,
  output logic [2:0]          o_fpu_rounding_mode,
  output logic [31:0]         o_fpu_int_src1,
  output logic [31:0]         o_fpu_int_src2,
  output logic [FP_WIDTH-1:0] o_fpu_fp_src1,
  output logic [FP_WIDTH-1:0] o_fpu_fp_src2,
  output logic [FP_WIDTH-1:0] o_fpu_fp_src3,
  input  logic                i_fpu_done,
  input  logic [31:0]         i_fpu_int_result,
  input  logic [FP_WIDTH-1:0] i_fpu_fp_result,
  input  logic                i_fpu_write_flags,
  input  fflags_t             i_fpu_write_flags_value,
  output logic                o_wb_valid,
  output logic [4:0]          o_wb_rd,
  output logic                o_wb_is_int,
  output logic [31:0]         o_wb_int_value,
  output logic [FP_WIDTH-1:0] o_wb_fp_value,
  output fflags_t             o_fflags_accum,
  input  logic                i_fflags_clear,
  output logic                o_watchdog_error
);

  fp_seq_state_e r_state, w_state_next;

  logic w_accept, w_done, w_wd_expired;
  fflags_t r_flags, r_accum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FpSeqIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush and reset dominate every decoded output so nothing leaks out in the killing cycle.
  always_comb begin
    w_state_next     = r_state;
    o_req_ready      = 1'b0;
    o_fpu_enable     = 1'b0;
    o_wb_valid       = 1'b0;
    w_done           = 1'b0;
    o_watchdog_error = 1'b0;
    o_fpu_flush      = 1'b0;
    if (i_rst) begin
      w_state_next = FpSeqIdle;
    end else if (i_flush) begin
      o_fpu_flush  = 1'b1;
      w_state_next = FpSeqIdle;
    end else begin
      unique case (r_state)
        FpSeqIdle: begin
          o_req_ready = 1'b1;
          if (i_req_valid) w_state_next = FpSeqBusy;
        end
        FpSeqBusy: begin
          o_fpu_enable = 1'b1;
          if (i_fpu_done) begin
            w_done       = 1'b1;
            w_state_next = FpSeqWb;
          end else if (w_wd_expired) begin
            o_fpu_flush      = 1'b1;
            o_watchdog_error = 1'b1;
            w_state_next     = FpSeqIdle;
          end
        end
        FpSeqWb: begin
          o_wb_valid   = 1'b1;
          w_state_next = FpSeqIdle;
        end
        default: w_state_next = FpSeqIdle;
      endcase
    end
  end

  assign w_accept = o_req_ready && i_req_valid;

  fp_op_sequencer_busy_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_busy_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_accept),
    .i_enable (o_fpu_enable && !i_fpu_done),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fpu_unit          <= FpUnitAdd;
      o_fpu_command       <= '0;
      o_fpu_rounding_mode <= '0;
      o_fpu_int_src1      <= '0;
      o_fpu_int_src2      <= '0;
      o_fpu_fp_src1       <= '0;
      o_fpu_fp_src2       <= '0;
      o_fpu_fp_src3       <= '0;
      o_wb_rd             <= '0;
      o_wb_is_int         <= 1'b0;
      o_wb_int_value      <= '0;
      o_wb_fp_value       <= '0;
      r_flags             <= '0;
      r_accum             <= '0;
    end else begin
      if (w_accept) begin
        o_fpu_unit          <= i_req_unit;
        o_fpu_command       <= i_req_command;
        o_fpu_rounding_mode <= i_req_rounding_mode;
        o_fpu_int_src1      <= i_req_int_src1;
        o_fpu_int_src2      <= i_req_int_src2;
        o_fpu_fp_src1       <= i_req_fp_src1;
        o_fpu_fp_src2       <= i_req_fp_src2;
        o_fpu_fp_src3       <= i_req_fp_src3;
        o_wb_rd             <= i_req_rd;
        o_wb_is_int         <= i_req_rd_is_int;
      end
      if (w_done) begin
        o_wb_int_value <= i_fpu_int_result;
        o_wb_fp_value  <= i_fpu_fp_result;
        r_flags        <= mask_flags(i_fpu_write_flags, i_fpu_write_flags_value);
      end
      // A coincident clear wipes history but keeps the flags of the op retiring now.
      if (o_wb_valid) begin
        r_accum <= fflags_t'((i_fflags_clear ? '0 : r_accum) | r_flags);
      end else if (i_fflags_clear) begin
        r_accum <= '0;
      end
    end
  end

  assign o_fflags_accum = r_accum;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer; writebacks are checked against a scoreboard of expected
// results queued at issue time.
module tb_fp_op_sequencer;
  import fp_op_sequencer_pkg::*;

  localparam int unsigned FpW = 32;
  localparam int unsigned WdCycles = 64;

  logic           clk = 1'b0;
  logic           rst, flush, req_valid, req_ready, req_rd_is_int;
  fp_unit_e       req_unit, fpu_unit;
  fp_command_u    req_command, fpu_command;
  logic [2:0]     req_rm, fpu_rm;
  logic [4:0]     req_rd, wb_rd;
  logic [31:0]    req_int_src1, req_int_src2, fpu_int_src1, fpu_int_src2;
  logic [FpW-1:0] req_fp_src1, req_fp_src2, req_fp_src3;
  logic [FpW-1:0] fpu_fp_src1, fpu_fp_src2, fpu_fp_src3;
  logic           fpu_enable, fpu_flush, fpu_done, fpu_write_flags;
  logic [31:0]    fpu_int_result, wb_int_value;
  logic [FpW-1:0] fpu_fp_result, wb_fp_value;
  fflags_t        fpu_write_flags_value, fflags_accum;
  logic           wb_valid, wb_is_int, fflags_clear, watchdog_error;

  always #5 clk = ~clk;

  fp_op_sequencer #(
    .FP_WIDTH(FpW),
    .WATCHDOG_CYCLES(WdCycles)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_unit(req_unit), .i_req_command(req_command), .i_req_rounding_mode(req_rm),
    .i_req_rd(req_rd), .i_req_rd_is_int(req_rd_is_int),
    .i_req_int_src1(req_int_src1), .i_req_int_src2(req_int_src2),
    .i_req_fp_src1(req_fp_src1), .i_req_fp_src2(req_fp_src2), .i_req_fp_src3(req_fp_src3),
    .o_fpu_enable(fpu_enable), .o_fpu_flush(fpu_flush),
    .o_fpu_unit(fpu_unit), .o_fpu_command(fpu_command), .o_fpu_rounding_mode(fpu_rm),
    .o_fpu_int_src1(fpu_int_src1), .o_fpu_int_src2(fpu_int_src2),
    .o_fpu_fp_src1(fpu_fp_src1), .o_fpu_fp_src2(fpu_fp_src2), .o_fpu_fp_src3(fpu_fp_src3),
    .i_fpu_done(fpu_done), .i_fpu_int_result(fpu_int_result), .i_fpu_fp_result(fpu_fp_result),
    .i_fpu_write_flags(fpu_write_flags), .i_fpu_write_flags_value(fpu_write_flags_value),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_is_int(wb_is_int),
    .o_wb_int_value(wb_int_value), .o_wb_fp_value(wb_fp_value),
    .o_fflags_accum(fflags_accum), .i_fflags_clear(fflags_clear),
    .o_watchdog_error(watchdog_error)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        is_int;
    logic [31:0] int_value;
    logic [31:0] fp_value;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wb_count = 0;
  logic s_req_ready, s_fpu_enable, s_fpu_flush, s_wb_valid, s_wd_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle's outputs mid-cycle, scores any writeback, then clocks once.
  task automatic cyc();
    wb_exp_t e;
    #1;
    s_req_ready  = req_ready;
    s_fpu_enable = fpu_enable;
    s_fpu_flush  = fpu_flush;
    s_wb_valid   = wb_valid;
    s_wd_err     = watchdog_error;
    if (wb_valid) begin
      wb_count++;
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_is_int", 32'(wb_is_int), 32'(e.is_int));
        chk("wb_int_value", wb_int_value, e.int_value);
        chk("wb_fp_value", wb_fp_value, e.fp_value);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input fp_unit_e unit, input logic [4:0] rd, input logic is_int,
                         input logic [31:0] isrc, input logic [31:0] fsrc);
    req_valid     = 1'b1;
    req_unit      = unit;
    req_command   = '0;
    req_rm        = 3'd1;
    req_rd        = rd;
    req_rd_is_int = is_int;
    req_int_src1  = isrc;
    req_int_src2  = isrc ^ 32'hFFFF_0000;
    req_fp_src1   = fsrc;
    req_fp_src2   = fsrc + 32'd1;
    req_fp_src3   = fsrc + 32'd2;
  endtask

  // Issues one op, answers done on the lat-th busy cycle, and checks the enable window.
  task automatic do_op(input fp_unit_e unit, input logic [4:0] rd, input logic is_int,
                       input logic [31:0] ires, input logic [31:0] fres, input int lat,
                       input logic wf, input logic [4:0] fv, input logic clr);
    wb_exp_t e;
    int en_cnt = 0;
    int wb0 = wb_count;
    logic ready_seen = 1'b0;
    set_req(unit, rd, is_int, 32'h1000 + 32'(rd), 32'h4000_0000 + 32'(rd));
    e.rd = rd; e.is_int = is_int; e.int_value = ires; e.fp_value = fres;
    sb.push_back(e);
    cyc();
    chk("issue_ready", 32'(s_req_ready), 32'd1);
    chk("fpu_unit_reg", 32'(fpu_unit), 32'(unit));
    chk("fpu_fp_src1_reg", fpu_fp_src1, 32'h4000_0000 + 32'(rd));
    req_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      fpu_done              = (i == lat);
      fpu_int_result        = ires;
      fpu_fp_result         = fres;
      fpu_write_flags       = wf;
      fpu_write_flags_value = fflags_t'(fv);
      cyc();
      en_cnt += int'(s_fpu_enable);
      ready_seen |= s_req_ready;
    end
    fpu_done = 1'b0;
    fflags_clear = clr;
    cyc();
    fflags_clear = 1'b0;
    chk("wb_strobe", 32'(s_wb_valid), 32'd1);
    chk("enable_cycles", 32'(en_cnt), 32'(lat));
    chk("ready_low_busy", 32'(ready_seen), 32'd0);
    chk("single_wb", 32'(wb_count - wb0), 32'd1);
  endtask

  initial begin
    int wb0;
    logic wd_early;
    rst = 1'b1; flush = 1'b0; fflags_clear = 1'b0; fpu_done = 1'b0;
    fpu_write_flags = 1'b0; fpu_write_flags_value = '0;
    fpu_int_result = '0; fpu_fp_result = '0;
    set_req(FpUnitAdd, 5'd0, 1'b0, '0, '0);
    req_valid = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(s_req_ready), 32'd0);
    chk("rst_fpu_flush", 32'(s_fpu_flush), 32'd0);
    chk("rst_accum", 32'(fflags_accum), 32'd0);
    chk("rst_fpu_int_src1", fpu_int_src1, 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_ready", 32'(s_req_ready), 32'd1);
    chk("idle_enable", 32'(s_fpu_enable), 32'd0);

    // Move with done tied high: done in the issue cycle must be ignored.
    begin
      wb_exp_t e;
      set_req(FpUnitMove, 5'd3, 1'b0, 32'h3F80_0000, 32'h0);
      fpu_done = 1'b1; fpu_fp_result = 32'h3F80_0000; fpu_int_result = 32'h0;
      e.rd = 5'd3; e.is_int = 1'b0; e.int_value = 32'h0; e.fp_value = 32'h3F80_0000;
      sb.push_back(e);
      cyc();
      chk("move_accept", 32'(s_req_ready), 32'd1);
      chk("move_no_wb_n", 32'(s_wb_valid), 32'd0);
      req_valid = 1'b0;
      cyc();
      chk("move_enable_n1", 32'(s_fpu_enable), 32'd1);
      cyc();
      chk("move_wb_n2", 32'(s_wb_valid), 32'd1);
      chk("move_wb_ready", 32'(s_req_ready), 32'd0);
      fpu_done = 1'b0;
      chk("move_accum", 32'(fflags_accum), 32'd0);
    end

    do_op(FpUnitFma, 5'd4, 1'b0, 32'h0, 32'h4040_0000, 2, 1'b1, 5'h01, 1'b0);
    chk("accum_nx", 32'(fflags_accum), 32'h01);
    do_op(FpUnitDiv, 5'd5, 1'b0, 32'h0, 32'h7F80_0000, 3, 1'b1, 5'h08, 1'b0);
    chk("accum_nx_dz", 32'(fflags_accum), 32'h09);
    do_op(FpUnitDiv, 5'd6, 1'b0, 32'h0, 32'hFF80_0000, 1, 1'b1, 5'h08, 1'b1);
    chk("accum_clear_or", 32'(fflags_accum), 32'h08);

    do_op(FpUnitSqrt, 5'd7, 1'b0, 32'h0, 32'h3FB5_04F3, 20, 1'b0, 5'h1F, 1'b0);
    chk("accum_masked", 32'(fflags_accum), 32'h08);

    // Flush on busy cycle 5 of a Sqrt while a new request is presented.
    wb0 = wb_count;
    set_req(FpUnitSqrt, 5'd8, 1'b0, 32'h0, 32'h4080_0000);
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    set_req(FpUnitCvt, 5'd9, 1'b1, 32'h55, 32'h0);
    flush = 1'b1;
    cyc();
    chk("flush_pulse", 32'(s_fpu_flush), 32'd1);
    chk("flush_no_accept", 32'(s_req_ready), 32'd0);
    chk("flush_no_wb", 32'(s_wb_valid), 32'd0);
    flush = 1'b0;
    begin
      wb_exp_t e;
      e.rd = 5'd9; e.is_int = 1'b1; e.int_value = 32'h0000_0055; e.fp_value = 32'h0;
      sb.push_back(e);
    end
    cyc();
    chk("post_flush_accept", 32'(s_req_ready), 32'd1);
    chk("post_flush_no_flush", 32'(s_fpu_flush), 32'd0);
    req_valid = 1'b0;
    fpu_done = 1'b1; fpu_int_result = 32'h55; fpu_fp_result = 32'h0; fpu_write_flags = 1'b0;
    cyc();
    fpu_done = 1'b0;
    cyc();
    chk("post_flush_wb", 32'(s_wb_valid), 32'd1);
    chk("flush_wb_count", 32'(wb_count - wb0), 32'd1);

    // Watchdog: done never comes.
    wb0 = wb_count;
    wd_early = 1'b0;
    set_req(FpUnitSqrt, 5'd10, 1'b0, 32'h0, 32'h4100_0000);
    cyc();
    req_valid = 1'b0;
    for (int i = 1; i < int'(WdCycles); i++) begin
      cyc();
      wd_early |= s_wd_err | s_fpu_flush;
    end
    chk("wd_not_early", 32'(wd_early), 32'd0);
    cyc();
    chk("wd_error", 32'(s_wd_err), 32'd1);
    chk("wd_flush", 32'(s_fpu_flush), 32'd1);
    cyc();
    chk("wd_idle", 32'(s_req_ready), 32'd1);
    chk("wd_err_pulse", 32'(s_wd_err), 32'd0);
    chk("wd_no_wb", 32'(wb_count - wb0), 32'd0);
    chk("wd_accum", 32'(fflags_accum), 32'h08);

    // Reset mid-busy with done in the same cycle.
    set_req(FpUnitMul, 5'd11, 1'b0, 32'h0, 32'h4120_0000);
    cyc();
    req_valid = 1'b0;
    cyc();
    rst = 1'b1; fpu_done = 1'b1; fpu_fp_result = 32'h1234_5678;
    cyc();
    chk("rst_busy_no_wb", 32'(s_wb_valid), 32'd0);
    chk("rst_busy_enable", 32'(s_fpu_enable), 32'd0);
    rst = 1'b0; fpu_done = 1'b0;
    cyc();
    chk("rst_after_wb", 32'(s_wb_valid), 32'd0);
    chk("rst_after_enable", 32'(s_fpu_enable), 32'd0);
    chk("rst_after_accum", 32'(fflags_accum), 32'd0);
    chk("rst_after_fp_src1", fpu_fp_src1, 32'd0);
    chk("rst_after_wb_fp", wb_fp_value, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("total_wb", 32'(wb_count), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
